// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if
//   CPU-side MIO handshake between the control unit (master) and the
//   memory/IO responder (slave).
//   Handshake: the master raises CPU_MIO together with MemRW, Addr_out and
//   Data_out. The slave captures them on the first IDLE clock edge that sees
//   CPU_MIO=1. The slave then answers with a single-cycle MIO_ready pulse,
//   and Data_in is meaningful only in that cycle. The master may drop
//   CPU_MIO in the MIO_ready cycle. If it keeps CPU_MIO high, a new request
//   is taken on the next IDLE edge.
//   Signals:
//     CPU_MIO   master->slave  request valid
//     MemRW     master->slave  1 = write, 0 = read
//     Addr_out  master->slave  byte address (bits [1:0] ignored)
//     Data_out  master->slave  write data
//     Data_in   slave->master  read data
//     MIO_ready slave->master  completion pulse
interface mio_bus_responder_if;
  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_out, Data_out,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_out, Data_out,
    output Data_in, MIO_ready
  );
endinterface

// File: rtl/mio_bus_responder.sv
// mio_bus_responder
//   Memory/IO responder on the far end of the CPU MIO handshake. It holds a
//   word RAM, an LED register and a free-running cycle counter. It inserts
//   WAIT_CYCLES wait states and then returns a one-cycle MIO_ready pulse
//   with the read data.
//   Ports:
//     clk, rst   rising-edge clock, synchronous active-high reset
//     bus        mio_bus_responder_if.slave handshake (see interface header)
//     LED        LED register contents
//     mio_err    sticky flag for unmapped accesses, cleared only by rst
//     dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//   Address map (word address = Addr_out[31:2]):
//     0x0000_0000 .. 4*2**RAM_AW-1 : RAM
//     0xF000_0000                  : LED (read returns zero-extended LED)
//     0xF000_0004                  : cycle counter (read-only, writes dropped)
//     anything else                : reads 0, writes dropped, sets mio_err
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int LED_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mio_bus_responder_if.slave   bus,
  output logic [LED_W-1:0]     LED,
  output logic                 mio_err,
  output logic [1:0]           dbg_state
);

  localparam int          RAM_DEPTH = 1 << RAM_AW;
  localparam logic [29:0] LED_WA    = 30'h3C00_0000;
  localparam logic [29:0] CNT_WA    = 30'h3C00_0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               err_q, err_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [31:0]        mem [RAM_DEPTH];

  logic               go_done;
  logic               hit_ram, hit_led, hit_cnt;
  logic [31:0]        rd_word;

  // Decode is done on addr_d so the entry edge into DONE sees the address
  // being latched on that same edge. This matters when WAIT_CYCLES = 0.
  // In WAIT and DONE, addr_d equals addr_q.
  always_comb begin
    hit_ram = (addr_d[29:RAM_AW] == '0);
    hit_led = (addr_d == LED_WA);
    hit_cnt = (addr_d == CNT_WA);
    rd_word = '0;
    if (hit_ram)      rd_word = mem[addr_d[RAM_AW-1:0]];
    else if (hit_led) rd_word = 32'(led_q);
    else if (hit_cnt) rd_word = cnt_d;  // value the counter holds during DONE
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = '0;
    ready_d = 1'b0;
    led_d   = led_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 32'd1;
    go_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.CPU_MIO) begin
          addr_d  = bus.Addr_out[31:2];
          wdata_d = bus.Data_out;
          we_d    = bus.MemRW;
          wcnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            go_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = S_DONE;
          go_done = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // The write is committed on the edge that leaves DONE. RAM writes
        // are handled in the RAM process below.
        if (we_q && hit_led) led_d = wdata_q[LED_W-1:0];
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers load on the edge entering DONE, so MIO_ready and
    // Data_in are flop outputs that are valid during the DONE cycle.
    // Writes return zero on Data_in.
    if (go_done) begin
      ready_d = 1'b1;
      if (!we_d) rdata_d = rd_word;
      if (!(hit_ram || hit_led || hit_cnt)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      led_q   <= led_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM is not reset. A reset on the closing edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_DONE && we_q && hit_ram)
      mem[addr_q[RAM_AW-1:0]] <= wdata_q;
  end

  assign bus.MIO_ready = ready_q;
  assign bus.Data_in   = rdata_q;
  assign LED           = led_q;
  assign mio_err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
module tb_mio_bus_responder;

  localparam int W = 65;  // {due_cycle[31:0], err, data[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mio_bus_responder_if bus0 ();
  mio_bus_responder_if bus1 ();
  logic [7:0] led0, led1;
  logic       err0, err1;
  logic [1:0] st0, st1;

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(2), .LED_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .LED(led0), .mio_err(err0), .dbg_state(st0)
  );
  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0), .LED_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .LED(led1), .mio_err(err1), .dbg_state(st1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;        // number of posedges so far
  int rst_edge = 0;   // last posedge that saw rst=1
  int w_of [2] = '{2, 0};
  logic err_m [2] = '{1'b0, 1'b0};
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always @(posedge clk) begin
    if (rst) rst_edge <= cyc + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int sel, input logic rdy, input logic [31:0] data, input logic err);
    logic [W-1:0] e;
    if (rdy) begin
      if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready dut%0d: got MIO_ready=1 expected 0 (cycle %0d)", sel, cyc);
      end else begin
        e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("dut%0d_ready_cycle", sel), cyc, e[64:33]);
        check($sformatf("dut%0d_data_in", sel), data, e[31:0]);
        check($sformatf("dut%0d_mio_err", sel), {31'd0, err}, {31'd0, e[32]});
      end
    end else begin
      check($sformatf("dut%0d_data_in_idle", sel), data, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus0.MIO_ready, bus0.Data_in, err0);
      mon(1, bus1.MIO_ready, bus1.Data_in, err1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic mio, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.CPU_MIO = mio; bus0.MemRW = we; bus0.Addr_out = addr; bus0.Data_out = data;
    end else begin
      bus1.CPU_MIO = mio; bus1.MemRW = we; bus1.Addr_out = addr; bus1.Data_out = data;
    end
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? bus0.MIO_ready : bus1.MIO_ready;
  endfunction

  task automatic push(input int sel, input int due, input logic [31:0] data);
    if (sel == 0) exp_q0.push_back({due[31:0], err_m[0], data});
    else          exp_q1.push_back({due[31:0], err_m[1], data});
  endtask

  // One request. The inputs are scrambled while waiting to show that the
  // DUT uses its latched copy. is_cnt expects the counter at the DONE cycle.
  task automatic req(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp,
                     input logic unmapped, input logic is_cnt);
    int due;
    int n;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, data);
    due = cyc + 1 + w_of[sel];
    if (unmapped) err_m[sel] = 1'b1;
    push(sel, due, is_cnt ? 32'(due - rst_edge) : exp);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rdy_of(sel) || n > 20) break;
      drive(sel, 1'b1, ~we, 32'hF000_0000, 32'hFFFF_FFFF);
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (n > 20) begin
      failures++;
      $display("FAIL handshake_timeout dut%0d: got no MIO_ready expected one within 20 cycles", sel);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int pulses;
    int due;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready0", {31'd0, bus0.MIO_ready}, 32'd0);
    check("rst_data0", bus0.Data_in, 32'd0);
    check("rst_led0", {24'd0, led0}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_state0", {30'd0, st0}, 32'd0);
    check("rst_ready1", {31'd0, bus1.MIO_ready}, 32'd0);
    rst = 1'b0;

    // RAM write then read
    req(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    req(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    // Byte-offset bits are ignored
    req(0, 1'b0, 32'h0000_0013, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // LED write and read back
    req(0, 1'b1, 32'hF000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("led_after_write", {24'd0, led0}, 32'h0000_00A5);
    req(0, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_00A5, 1'b0, 1'b0);

    // Counter write ignored, no error
    req(0, 1'b1, 32'hF000_0004, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0);

    // Back-to-back counter reads with CPU_MIO held high
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'hF000_0004, 32'h0);
    due = cyc + 1 + 2;
    push(0, due, 32'(due - rst_edge));
    push(0, due + 4, 32'(due + 4 - rst_edge));
    n = 0;
    pulses = 0;
    while (pulses < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (bus0.MIO_ready) pulses++;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b_pulse_count", pulses, 32'd2);
    repeat (6) @(negedge clk);

    // Unmapped read sets a sticky error
    req(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
    req(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    req(0, 1'b1, 32'h0000_1000, 32'h1, 32'h0, 1'b1, 1'b0);
    check("err_sticky", {31'd0, err0}, 32'd1);

    // A reset during the WAIT state of a write drops that write
    req(0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wait_state_before_rst", {30'd0, st0}, 32'd1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    err_m[0] = 1'b0;
    err_m[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("err_cleared", {31'd0, err0}, 32'd0);
    check("led_cleared", {24'd0, led0}, 32'd0);
    req(0, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);

    // Zero-wait build
    req(1, 1'b1, 32'h0000_0040, 32'h55AA_33CC, 32'h0, 1'b0, 1'b0);
    req(1, 1'b0, 32'h0000_0040, 32'h0, 32'h55AA_33CC, 1'b0, 1'b0);
    req(1, 1'b0, 32'hF000_0004, 32'h0, 32'h0, 1'b0, 1'b1);
    req(1, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("queue0_empty", exp_q0.size(), 32'd0);
    check("queue1_empty", exp_q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
